// File: rtl/mole_spawner_if.sv
// mole_spawner_if: bundles the spawner's game-side signals.
//   game_in_progress  : level, high while a game runs (into spawner)
//   full_clear_hit    : 1-cycle pulse, last lit mole was hit (into spawner)
//   mole_positions    : registered mask of raised moles (out of spawner)
//   round_count       : rounds completed since game start, saturating
//   up_cycles_cur     : up-window length for the current/next round
// master = spawner side, slave = consumer/driver side.
interface mole_spawner_if #(
  parameter int NUM_HOLES = 18
);
  logic                 game_in_progress;
  logic                 full_clear_hit;
  logic [NUM_HOLES-1:0] mole_positions;
  logic [15:0]          round_count;
  logic [31:0]          up_cycles_cur;

  modport master (
    input  game_in_progress, full_clear_hit,
    output mole_positions, round_count, up_cycles_cur
  );

  modport slave (
    output game_in_progress, full_clear_hit,
    input  mole_positions, round_count, up_cycles_cur
  );
endinterface

// File: rtl/mole_spawner.sv
// mole_spawner: per-round mole mask generator feeding the hit detector.
// Alternates a mole-down gap (DOWN) with a pick phase (PICK) and a mole-up
// window (UP). The up window shrinks by UP_CYCLES_STEP each round down to
// UP_CYCLES_MIN; a full clear ends it early. Hole choice comes from a
// free-running 32-bit Galois LFSR.
// Ports:
//   clk   : clock, posedge only
//   reset : synchronous, active-high
//   bus   : mole_spawner_if.master (game/clear in, mask/round/window out)
module mole_spawner #(
  parameter int          NUM_HOLES      = 18,
  parameter int          MAX_MOLES      = 3,
  parameter int          DOWN_CYCLES    = 25_000_000,
  parameter int          UP_CYCLES_INIT = 75_000_000,
  parameter int          UP_CYCLES_STEP = 2_500_000,
  parameter int          UP_CYCLES_MIN  = 15_000_000,
  parameter logic [31:0] LFSR_SEED      = 32'hACE1_2468
) (
  input logic          clk,
  input logic          reset,
  mole_spawner_if.master bus
);

  localparam logic [31:0] TAPS      = 32'h8020_0003;
  localparam logic [7:0]  MM8       = 8'(MAX_MOLES);
  localparam logic [7:0]  NH8       = 8'(NUM_HOLES);
  localparam logic [31:0] DOWN_LAST = 32'(DOWN_CYCLES - 1);
  localparam logic [31:0] UP_INIT   = 32'(UP_CYCLES_INIT);
  localparam logic [31:0] UP_STEP   = 32'(UP_CYCLES_STEP);
  localparam logic [31:0] UP_MIN    = 32'(UP_CYCLES_MIN);

  typedef enum logic [1:0] {IDLE, DOWN, PICK, UP} state_t;

  state_t               state;
  logic [31:0]          lfsr;
  logic [31:0]          down_cnt;
  logic [31:0]          up_cnt;
  logic [31:0]          up_cur;
  logic [15:0]          round_q;
  logic [NUM_HOLES-1:0] mask_q;
  logic [NUM_HOLES-1:0] work_mask;
  logic [7:0]           pick_cnt;
  logic [7:0]           k_reg;
  logic                 pick_entry;

  logic [31:0]          lfsr_next;
  logic [7:0]           k_new;
  logic [7:0]           k_eff;
  logic [7:0]           idx;
  logic [NUM_HOLES-1:0] onehot;
  logic                 dup;
  logic [NUM_HOLES-1:0] pick_mask_nxt;
  logic [7:0]           pick_cnt_nxt;
  logic                 up_done;
  logic [31:0]          up_dec;

  always_comb begin
    lfsr_next     = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'h0);
    k_new         = (lfsr[15:8] % MM8) + 8'd1;
    // k is latched on the entry cycle but that same cycle already picks.
    k_eff         = pick_entry ? k_new : k_reg;
    idx           = lfsr[7:0] % NH8;
    onehot        = NUM_HOLES'(1) << idx;
    dup           = |(work_mask & onehot);
    pick_mask_nxt = work_mask | onehot;
    pick_cnt_nxt  = pick_cnt + {7'd0, ~dup};
    up_done       = bus.full_clear_hit || (up_cnt == up_cur - 32'd1);
    // up_cur >= UP_MIN always holds, so the subtraction below cannot wrap.
    up_dec        = ((up_cur - UP_MIN) > UP_STEP) ? (up_cur - UP_STEP) : UP_MIN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lfsr       <= LFSR_SEED;
      mask_q     <= '0;
      round_q    <= 16'd0;
      up_cur     <= UP_INIT;
      down_cnt   <= 32'd0;
      up_cnt     <= 32'd0;
      work_mask  <= '0;
      pick_cnt   <= 8'd0;
      k_reg      <= 8'd0;
      pick_entry <= 1'b0;
    end else begin
      lfsr <= lfsr_next;
      if (state != IDLE && !bus.game_in_progress) begin
        // Abort: round_count is kept until the next game start reloads it.
        state  <= IDLE;
        mask_q <= '0;
      end else begin
        case (state)
          IDLE: begin
            mask_q <= '0;
            if (bus.game_in_progress) begin
              state    <= DOWN;
              down_cnt <= 32'd0;
              round_q  <= 16'd0;
              up_cur   <= UP_INIT;
            end
          end
          DOWN: begin
            if (down_cnt == DOWN_LAST) begin
              state      <= PICK;
              work_mask  <= '0;
              pick_cnt   <= 8'd0;
              pick_entry <= 1'b1;
            end else begin
              down_cnt <= down_cnt + 32'd1;
            end
          end
          PICK: begin
            pick_entry <= 1'b0;
            if (pick_entry) k_reg <= k_new;
            work_mask <= pick_mask_nxt;
            pick_cnt  <= pick_cnt_nxt;
            if (pick_cnt_nxt == k_eff) begin
              mask_q <= pick_mask_nxt;
              up_cnt <= 32'd0;
              state  <= UP;
            end
          end
          UP: begin
            if (up_done) begin
              mask_q   <= '0;
              if (round_q != 16'hFFFF) round_q <= round_q + 16'd1;
              up_cur   <= up_dec;
              down_cnt <= 32'd0;
              state    <= DOWN;
            end else begin
              up_cnt <= up_cnt + 32'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.mole_positions = mask_q;
  assign bus.round_count    = round_q;
  assign bus.up_cycles_cur  = up_cur;

endmodule
